mcu_cmd_rx: RTL
===============

MCU_CMD_RX -- requirements
Module: mcu_cmd_rx

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 868: clk cycles per UART bit (legal range 8..65535).
REQ-002 SHALL have parameter UPD_SET, default 8'h5A: command byte that sets update_flag.
REQ-003 SHALL have parameter UPD_CLR, default 8'hA5: command byte that clears update_flag.
REQ-004 SHALL have parameter RECFG_CMD, default 8'h3C: command byte requesting reconfiguration.
REQ-005 SHALL have port clk, input, 1: single system clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port mcu_rx, input, 1: asynchronous UART line from the MCU, idle high.
REQ-008 SHALL have port byte_out, output, 8: last received data byte.
REQ-009 SHALL have port byte_out_en, output, 1: one-cycle strobe marking byte_out valid.
REQ-010 SHALL have port frame_err, output, 1: one-cycle strobe on a bad stop bit.
REQ-011 SHALL have port update_flag, output, 1: level; MCU reports a new image is pending.
REQ-012 SHALL have port reconfig_req, output, 1: one-cycle strobe on RECFG_CMD.
REQ-013 SHALL have port cmd_unknown, output, 1: one-cycle strobe on a valid byte matching no command.

Function
REQ-014 SHALL pass mcu_rx through a two-flop synchronizer; all decoding uses the synchronized value (rx_s).
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-016 IDLE -> START SHALL occur on the first cycle rx_s is low; the bit counter loads 0.
REQ-017 START SHALL sample rx_s at count BIT_CYCLES/2-1: low -> DATA with counter reset; high -> IDLE (glitch, no strobe).
REQ-018 DATA SHALL sample rx_s every BIT_CYCLES cycles, shifting 8 bits LSB first, then go to STOP.
REQ-019 STOP SHALL sample rx_s one BIT_CYCLES after the last data sample: high -> byte_out updated and byte_out_en pulsed next cycle, then IDLE; low -> frame_err pulsed, byte_out unchanged, then WAIT_IDLE.
REQ-020 WAIT_IDLE SHALL stay until rx_s is high for one cycle, then go to IDLE (break/stuck-low handling).
REQ-021 Latency from the stop-bit sample to byte_out_en SHALL be exactly 1 cycle.
REQ-022 On the cycle after byte_out_en, the decode stage SHALL act: UPD_SET sets update_flag to 1; UPD_CLR clears it to 0; RECFG_CMD pulses reconfig_req; any other byte pulses cmd_unknown.
REQ-023 update_flag SHALL hold its value between commands; a repeated UPD_SET SHALL leave it at 1 with no glitch.
REQ-024 The bit counter SHALL be 16 bits and SHALL never wrap within a frame.
REQ-025 A new start bit detected in IDLE SHALL be accepted even in the same cycle the decode stage acts on the previous byte (back-to-back frames, stop bit of exactly 1 bit).
REQ-026 At most one of byte_out_en and frame_err SHALL be high in any cycle.

Reset
REQ-027 On rst the FSM SHALL enter IDLE, and the counter and shift register SHALL clear.
REQ-028 On rst the synchronizer flops SHALL go to 1.
REQ-029 On rst byte_out SHALL be 0, and byte_out_en, frame_err, update_flag, reconfig_req and cmd_unknown SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial byte with no strobe; the next falling edge after release starts a new frame.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the default command byte constants (8'h5A, 8'hA5, 8'h3C), alongside the status-byte codes sent to the MCU (8'hAC, 8'h59, 8'hA6, 8'h55, 8'hAA).
REQ-032 The serial deserializer SHALL be one sub-module, s_port_byte_in (clk, reset, s_in, byte_out, byte_out_en, frame_err); mcu_cmd_rx SHALL add the command decode around it.

Verification (bench uses BIT_CYCLES=16)
REQ-033 Frame 8'h5A with a good stop bit -> byte_out=8'h5A; byte_out_en pulses once, 1 cycle after the stop sample; update_flag=1 on the following cycle.
REQ-034 8'h5A followed back-to-back by 8'hA5 -> two byte_out_en strobes 160 cycles apart; update_flag returns to 0.
REQ-035 Frame 8'h3C -> reconfig_req high for exactly 1 cycle; update_flag unchanged.
REQ-036 Frame 8'h77 with stop bit forced low, line held low 40 cycles -> frame_err for 1 cycle, no byte_out_en, FSM in WAIT_IDLE until the line goes high; a following 8'h77 with a good stop bit -> cmd_unknown for 1 cycle.
REQ-037 Low glitch of 4 cycles on an idle line -> no strobe of any kind; FSM back in IDLE.
REQ-038 rst asserted during bit 4 of 8'h5A -> no strobes, all outputs 0; the next full 8'hA5 frame is received correctly.

Source files
------------

// File: rtl/mcu_cmd_rx_pkg.sv
// Shared definitions for the MCU command receiver: deserializer state encoding,
// command byte defaults and status byte codes exchanged with the MCU.
package mcu_cmd_rx_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BIT_IDX_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

    // Default command bytes received from the MCU
    localparam logic [DATA_W-1:0] CMD_UPD_SET = 8'h5A;
    localparam logic [DATA_W-1:0] CMD_UPD_CLR = 8'hA5;
    localparam logic [DATA_W-1:0] CMD_RECFG   = 8'h3C;

    // Status byte codes sent back to the MCU
    localparam logic [DATA_W-1:0] STS_ACK    = 8'hAC;
    localparam logic [DATA_W-1:0] STS_READY  = 8'h59;
    localparam logic [DATA_W-1:0] STS_NACK   = 8'hA6;
    localparam logic [DATA_W-1:0] STS_SYNC_A = 8'h55;
    localparam logic [DATA_W-1:0] STS_SYNC_B = 8'hAA;

    typedef enum logic [1:0] {
        DEC_SET     = 2'd0,
        DEC_CLR     = 2'd1,
        DEC_RECFG   = 2'd2,
        DEC_UNKNOWN = 2'd3
    } cmd_dec_e;

    // Classify a received byte; earlier matches win if command bytes collide
    function automatic cmd_dec_e classify_cmd(
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] set_b,
        input logic [DATA_W-1:0] clr_b,
        input logic [DATA_W-1:0] recfg_b
    );
        cmd_dec_e r;
        if (b == set_b) begin
            r = DEC_SET;
        end else if (b == clr_b) begin
            r = DEC_CLR;
        end else if (b == recfg_b) begin
            r = DEC_RECFG;
        end else begin
            r = DEC_UNKNOWN;
        end
        return r;
    endfunction

endpackage

// File: rtl/s_port_byte_in.sv
// UART byte deserializer (8N1, LSB first) with two-flop input synchronizer,
// mid-bit sampling and framing-error / stuck-low handling.
module s_port_byte_in
    import mcu_cmd_rx_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 868
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_in,
    output logic [DATA_W-1:0] byte_out,
    output logic              byte_out_en,
    output logic              frame_err
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_W - 1);

    logic [1:0]           sync_q;
    logic                 rx_s;
    rx_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_IDX_W-1:0] bit_idx_q;
    logic [DATA_W-1:0]    shift_q;
    logic [DATA_W-1:0]    byte_q;
    logic                 byte_en_q;
    logic                 frame_err_q;

    assign rx_s        = sync_q[1];
    assign byte_out    = byte_q;
    assign byte_out_en = byte_en_q;
    assign frame_err   = frame_err_q;

    // Synchronizer, bit timing and frame state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= 2'b11;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_q      <= '0;
            byte_en_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], s_in};
            byte_en_q   <= 1'b0;
            frame_err_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end

                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        // A start bit that is gone by mid-bit is a glitch
                        state_q   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[DATA_W-1:1]};
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_STOP: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            byte_q    <= shift_q;
                            byte_en_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_WAIT_IDLE: begin
                    // Break or stuck-low line: resume only once it returns high
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mcu_cmd_rx.sv
// MCU command receiver: deserializes bytes from the MCU UART line and decodes
// them into the update flag, reconfiguration request and unknown-command strobe.
module mcu_cmd_rx
    import mcu_cmd_rx_pkg::*;
#(
    parameter int unsigned       BIT_CYCLES = 868,
    parameter logic [DATA_W-1:0] UPD_SET    = CMD_UPD_SET,
    parameter logic [DATA_W-1:0] UPD_CLR    = CMD_UPD_CLR,
    parameter logic [DATA_W-1:0] RECFG_CMD  = CMD_RECFG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mcu_rx,
    output logic [DATA_W-1:0] byte_out,
    output logic              byte_out_en,
    output logic              frame_err,
    output logic              update_flag,
    output logic              reconfig_req,
    output logic              cmd_unknown
);

    logic [DATA_W-1:0] rx_byte;
    logic              rx_en;
    logic              rx_ferr;
    logic              update_flag_q;
    logic              reconfig_q;
    logic              unknown_q;

    s_port_byte_in #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .reset       (rst),
        .s_in        (mcu_rx),
        .byte_out    (rx_byte),
        .byte_out_en (rx_en),
        .frame_err   (rx_ferr)
    );

    assign byte_out     = rx_byte;
    assign byte_out_en  = rx_en;
    assign frame_err    = rx_ferr;
    assign update_flag  = update_flag_q;
    assign reconfig_req = reconfig_q;
    assign cmd_unknown  = unknown_q;

    // Decode stage acts the cycle after each valid byte strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            update_flag_q <= 1'b0;
            reconfig_q    <= 1'b0;
            unknown_q     <= 1'b0;
        end else begin
            reconfig_q <= 1'b0;
            unknown_q  <= 1'b0;
            if (rx_en) begin
                unique case (classify_cmd(rx_byte, UPD_SET, UPD_CLR, RECFG_CMD))
                    DEC_SET:   update_flag_q <= 1'b1;
                    DEC_CLR:   update_flag_q <= 1'b0;
                    DEC_RECFG: reconfig_q    <= 1'b1;
                    default:   unknown_q     <= 1'b1;
                endcase
            end
        end
    end

endmodule
